// File: rtl/clock_time_pkg.sv
// clock_time_pkg: shared constants, run-state type and wrap-around helpers
// for the clock time controller.
//   ADDR_*   : Avalon word addresses of the four registers
//   *_W      : field widths of hour, minute and seconds
//   *_MAX    : inclusive upper limits used for range checks and wrapping
//   HOUR_RST : hour value loaded at reset
package clock_time_pkg;
    localparam logic [1:0] ADDR_HOUR   = 2'd0;
    localparam logic [1:0] ADDR_MINUTE = 2'd1;
    localparam logic [1:0] ADDR_ALARM  = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;
    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [HOUR_W-1:0] HOUR_RST = 5'd12;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    typedef enum logic {ST_STOP = 1'b0, ST_RUN = 1'b1} run_state_t;
    function automatic logic [HOUR_W-1:0] hour_inc(input logic [HOUR_W-1:0] h);
        return (h == HOUR_MAX) ? '0 : h + 1'b1;
    endfunction
    // Seconds and minutes share the 0..59 range, so one helper serves both.
    function automatic logic [MIN_W-1:0] sixty_inc(input logic [MIN_W-1:0] m);
        return (m == MIN_MAX) ? '0 : m + 1'b1;
    endfunction
endpackage

// File: rtl/clock_time_controller_prescaler.sv
// tick_prescaler: divides clk down to a one-cycle tick every TICK_CYCLES cycles.
//   clk, reset_n : clock and asynchronous active-low reset
//   run          : count enable; counter holds its value while low
//   clear        : synchronous restart of the count from 0
//   tick         : high in the cycle the counter wraps from TICK_CYCLES-1
module tick_prescaler
    import clock_time_pkg::*;
#(
    parameter int TICK_CYCLES = 50000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic clear,
    output logic tick
);
    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick = run && (cnt_q == LAST);
    always_comb cnt_d = clear ? '0 : !run ? cnt_q : tick ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
endmodule

// File: rtl/clock_time_controller.sv
// clock_time_controller: Avalon-MM hour/minute timekeeper with alarm interrupt.
//   clk, reset_n          : clock and asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata    : Avalon-MM slave write port
//   readdata              : combinational read mux (HOUR, MINUTE, ALARM, CTRL)
//   hour_out, minute_out  : current time, zero-extended
//   tick                  : one-cycle pulse per second
//   irq                   : level alarm interrupt (pending && enable)
module clock_time_controller
    import clock_time_pkg::*;
#(
    parameter int TICK_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [15:0] hour_out,
    output logic [15:0] minute_out,
    output logic        tick,
    output logic        irq
);
    logic [HOUR_W-1:0] hour_q, hour_d, alarm_hour_q, alarm_hour_d;
    logic [MIN_W-1:0]  min_q, min_d, alarm_min_q, alarm_min_d;
    logic [SEC_W-1:0]  sec_q, sec_d;
    logic              alarm_en_q, alarm_en_d, pend_q, pend_d;
    run_state_t        state_q, state_d;
    logic wr, wr_hour, wr_min, wr_alarm, wr_ctrl, sec_wrap, min_wrap, alarm_hit;
    assign wr       = chipselect && !write_n;
    assign wr_hour  = wr && address == ADDR_HOUR && writedata <= 32'(HOUR_MAX);
    assign wr_min   = wr && address == ADDR_MINUTE && writedata <= 32'(MIN_MAX);
    assign wr_alarm = wr && address == ADDR_ALARM && writedata[12:8] <= HOUR_MAX && writedata[5:0] <= MIN_MAX;
    assign wr_ctrl  = wr && address == ADDR_CTRL;
    assign sec_wrap = tick && sec_q == MIN_MAX;
    assign min_wrap = sec_wrap && min_q == MIN_MAX;
    tick_prescaler #(.TICK_CYCLES(TICK_CYCLES)) u_presc (
        .clk     (clk),
        .reset_n (reset_n),
        .run     (state_q == ST_RUN),
        .clear   (wr_min),
        .tick    (tick)
    );
    // A CPU write to a field overrides the sequencer for that field; a minute
    // write also swallows the hour carry, since the carry came from the old minute.
    always_comb begin
        sec_d        = wr_min ? '0 : tick ? sixty_inc(sec_q) : sec_q;
        min_d        = wr_min ? writedata[MIN_W-1:0] : sec_wrap ? sixty_inc(min_q) : min_q;
        hour_d       = wr_hour ? writedata[HOUR_W-1:0] : (min_wrap && !wr_min) ? hour_inc(hour_q) : hour_q;
        alarm_hour_d = wr_alarm ? writedata[12:8] : alarm_hour_q;
        alarm_min_d  = wr_alarm ? writedata[5:0] : alarm_min_q;
        alarm_en_d   = wr_alarm ? writedata[16] : alarm_en_q;
        // Only a sequencer minute rollover may raise the alarm; CPU time sets never do.
        alarm_hit    = sec_wrap && !wr_min && !wr_hour && alarm_en_q && hour_d == alarm_hour_q && min_d == alarm_min_q;
        pend_d       = alarm_hit || (pend_q && !(wr_ctrl && writedata[0]));
        state_d      = wr_ctrl ? (writedata[1] ? ST_RUN : ST_STOP) : state_q;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            hour_q       <= HOUR_RST;
            min_q        <= '0;
            sec_q        <= '0;
            alarm_hour_q <= '0;
            alarm_min_q  <= '0;
            alarm_en_q   <= 1'b0;
            pend_q       <= 1'b0;
            state_q      <= ST_RUN;
        end else begin
            hour_q       <= hour_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            alarm_hour_q <= alarm_hour_d;
            alarm_min_q  <= alarm_min_d;
            alarm_en_q   <= alarm_en_d;
            pend_q       <= pend_d;
            state_q      <= state_d;
        end
    assign irq        = pend_q && alarm_en_q;
    assign hour_out   = {11'b0, hour_q};
    assign minute_out = {10'b0, min_q};
    assign readdata   = (address == ADDR_HOUR)   ? {27'b0, hour_q} :
                        (address == ADDR_MINUTE) ? {26'b0, min_q} :
                        (address == ADDR_ALARM)  ? {15'b0, alarm_en_q, 3'b0, alarm_hour_q, 2'b0, alarm_min_q} :
                                                   {18'b0, sec_q, 6'b0, state_q == ST_RUN, pend_q};
endmodule

// File: doc/clock_time_controller.md
# clock_time_controller

Avalon-MM timekeeping controller that owns the hour and minute display registers of the alarm-clock system. It arbitrates each register between CPU writes and an internal one-second increment sequencer. It also compares the running time against a programmable alarm and raises an interrupt. It sits on the same system interconnect as the plain PIO slaves and drives the hour/minute display outputs directly.

## Interface
- TICK_CYCLES, 50000000, clk cycles per one-second tick (≥2)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational from address; unused bits 0
- hour_out  out  16  current hour 0..23, zero-extended
- minute_out  out  16  current minute 0..59, zero-extended
- tick  out  1  one-cycle pulse on each second tick
- irq  out  1  alarm interrupt, level

## Operation
- Address map. A write is chipselect && !write_n.
  - 0 HOUR rw [4:0]
  - 1 MINUTE rw [5:0]
  - 2 ALARM rw: [16] enable, [12:8] alarm hour, [5:0] alarm minute
  - 3 CTRL: [0] pending (write 1 clears), [1] run (rw), [13:8] seconds (ro)
- Range checks:
  - A HOUR write with value > 23, or a MINUTE write with value > 59, is ignored and the register holds.
  - ALARM fields are range-checked the same way; if either field is out of range, the whole write is ignored.
- Run state. There are two states, RUN and STOP, and CTRL.run selects between them.
  - STOP: the prescaler and seconds counter freeze, and tick stays 0.
  - STOP -> RUN resumes counting from the held prescaler value.
- Prescaler. It counts 0..TICK_CYCLES-1 in RUN. At TICK_CYCLES-1 it wraps to 0 and tick pulses.
- Increment chain on tick:
  - seconds 59 -> 0 carries to minutes.
  - minutes 59 -> 0 carries to hours.
  - hours 23 -> 0.
- A MINUTE write clears seconds and the prescaler to 0. A HOUR write does not.
- Simultaneous events. A CPU write always wins over the sequencer for the written field.
  - MINUTE write in a carry cycle: the written value stands, seconds = 0, and no hour carry occurs.
  - HOUR write in a cycle where minutes carry: the written hour stands, and minutes wrap to 0.
- Alarm:
  - pending sets only on a tick that makes seconds 0 with the new hour:minute equal to the alarm, while enable = 1.
  - Setting the time by CPU write never sets pending.
  - irq = pending && enable.
  - If a pending set and a CTRL write-1-clear occur in the same cycle, the set wins.

## Timing
- Reset values:
  - hour 12, minute 0, seconds 0, prescaler 0
  - alarm 0:00 with enable 0
  - pending 0, run 1
  - tick 0, irq 0, hour_out 12, minute_out 0
- A register write takes effect on the clock edge of the write cycle; the outputs reflect it in the next cycle.
- Reads have zero wait states; readdata is valid in the same cycle as address.
- tick asserts in the cycle the prescaler wraps.
  - hour_out and minute_out update at the same edge, so they show the new time in the cycle after tick.
  - irq rises in the cycle after the matching tick.
- Asserting reset_n mid-count clears everything asynchronously. The first tick after release occurs exactly TICK_CYCLES cycles after the first active clk edge.

## Structure
- Package clock_time_pkg:
  - address constants ADDR_HOUR..ADDR_CTRL
  - field widths HOUR_W = 5, MIN_W = 6, SEC_W = 6
  - limits HOUR_MAX = 23, MIN_MAX = 59
  - reset constant HOUR_RST = 12
- Sub-module tick_prescaler (TICK_CYCLES, clk, reset_n, run, clear, tick).
- The top level holds the time and alarm registers, the write/increment arbitration, and the read mux.

## Test plan
All scenarios use TICK_CYCLES = 4.
- Reset release -> hour_out 12, minute_out 0, irq 0, and the first tick at cycle 4.
- Write HOUR = 23, MINUTE = 59, then run 60 ticks -> hour_out 0, minute_out 0, CTRL seconds 0.
- Write HOUR = 24, then read addr 0 -> 12. Write MINUTE = 60, then read addr 1 -> 0.
- Alarm 12:01 enabled, run 60 ticks -> irq = 1 one cycle after the 60th tick. Write CTRL = 1 -> irq = 0.
- Write MINUTE = 5 in the cycle of the carry from 12:00:59 -> time reads 12:05:00.
- Clear run for 20 cycles, then set it again -> no tick during the stop, and seconds unchanged across the stop.
